// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one sram-like memory port between the instruction
// fetch requester and the data requester. A grant is held until its address
// handshake completes. An in-order tag FIFO records the owner of each
// accepted request so that every response is routed back to its issuer.
// Optional feature: define MEM_ARB_RR_EN for round-robin arbitration
// (default build uses fixed data-over-inst priority).
module mem_port_arbiter #(
    parameter int OUTSTANDING = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    localparam int CNT_W      = $clog2(OUTSTANDING + 1)
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,
    output logic              mem_req,
    output logic              mem_wr,
    output logic [1:0]        mem_size,
    output logic [3:0]        mem_wstrb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_addr_ok,
    input  logic              mem_data_ok,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  outstanding_cnt
);

    localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD_I = 2'd1,
        HOLD_D = 2'd2
    } state_t;

    state_t           state_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             tag_mem [OUTSTANDING];

    logic fifo_full;
    logic fifo_empty;
    logic prio_data;
    logic pick_data;
    logic grant_data;
    logic push;
    logic pop;
    logic head_is_data;

    assign fifo_full  = (count_q == CNT_W'(OUTSTANDING));
    assign fifo_empty = (count_q == '0);

`ifdef MEM_ARB_RR_EN
    // last_grant_q: 1 = data was granted last, 0 = inst was granted last
    logic last_grant_q;
    assign prio_data = ~last_grant_q;

    // Remember the owner of every completed address handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant_q <= 1'b1;
        end else if (push) begin
            last_grant_q <= grant_data;
        end
    end
`else
    assign prio_data = 1'b1;
`endif

    // Winner selection in IDLE; a held grant overrides it in HOLD states
    assign pick_data  = data_req & (~inst_req | prio_data);
    assign grant_data = (state_q == IDLE) ? pick_data : (state_q == HOLD_D);

    // Request is masked while in reset so the port is quiet immediately
    assign mem_req = resetn & ((state_q == IDLE) ? (~fifo_full & (inst_req | data_req))
                                                 : 1'b1);

    assign mem_wr    = grant_data ? data_wr    : inst_wr;
    assign mem_size  = grant_data ? data_size  : inst_size;
    assign mem_wstrb = grant_data ? data_wstrb : inst_wstrb;
    assign mem_addr  = grant_data ? data_addr  : inst_addr;
    assign mem_wdata = grant_data ? data_wdata : inst_wdata;

    assign push         = mem_req & mem_addr_ok;
    assign inst_addr_ok = push & ~grant_data;
    assign data_addr_ok = push & grant_data;

    assign pop          = mem_data_ok & ~fifo_empty;
    assign head_is_data = tag_mem[rd_ptr_q];
    assign inst_data_ok = pop & ~head_is_data;
    assign data_data_ok = pop & head_is_data;

    assign inst_rdata      = mem_rdata;
    assign data_rdata      = mem_rdata;
    assign outstanding_cnt = count_q;

    // Grant FSM: lock the winner until its address handshake completes
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_req && !mem_addr_ok) begin
                        state_q <= pick_data ? HOLD_D : HOLD_I;
                    end
                end
                HOLD_I, HOLD_D: begin
                    if (mem_addr_ok) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag FIFO pointers and occupancy
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Tag storage; contents are meaningful only between the pointers
    always_ff @(posedge clk) begin
        if (push) begin
            tag_mem[wr_ptr_q] <= grant_data;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model:
// an owner queue for accepted requests plus the currently held requester.
module tb_mem_port_arbiter;

    localparam int OUTSTANDING = 2;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int CNT_W       = $clog2(OUTSTANDING + 1);

    logic              clk;
    logic              resetn;
    logic              inst_req, inst_wr;
    logic [1:0]        inst_size;
    logic [3:0]        inst_wstrb;
    logic [ADDR_W-1:0] inst_addr;
    logic [DATA_W-1:0] inst_wdata;
    logic              inst_addr_ok, inst_data_ok;
    logic [DATA_W-1:0] inst_rdata;
    logic              data_req, data_wr;
    logic [1:0]        data_size;
    logic [3:0]        data_wstrb;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_addr_ok, data_data_ok;
    logic [DATA_W-1:0] data_rdata;
    logic              mem_req, mem_wr;
    logic [1:0]        mem_size;
    logic [3:0]        mem_wstrb;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_addr_ok, mem_data_ok;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  outstanding_cnt;

    mem_port_arbiter #(
        .OUTSTANDING(OUTSTANDING),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
        .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
        .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
        .outstanding_cnt(outstanding_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: owners of accepted-but-unanswered requests (0=inst,1=data),
    // requester currently holding the port (-1 none) and last granted owner.
    int owners[$];
    int held      = -1;
    int last_gnt  = 1;
    bit pend_i    = 0;
    bit pend_d    = 0;
    int cyc       = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        owners.delete();
        held     = -1;
        last_gnt = 1;
        pend_i   = 0;
        pend_d   = 0;
    endtask

    // One randomized cycle: drive, check combinational outputs, advance model
    task automatic run_cycle();
        bit exp_req;
        int gnt;
        bit hs;
        bit pop;
        int head;
        @(negedge clk);
        cyc++;
        if (!pend_i) begin
            inst_req   = ($urandom_range(0, 9) < 6);
            inst_wr    = 1'b0;
            inst_size  = 2'($urandom_range(0, 3));
            inst_wstrb = 4'($urandom);
            inst_addr  = $urandom;
            inst_wdata = $urandom;
        end
        if (!pend_d) begin
            data_req   = ($urandom_range(0, 9) < 6);
            data_wr    = 1'($urandom);
            data_size  = 2'($urandom_range(0, 3));
            data_wstrb = 4'($urandom);
            data_addr  = $urandom;
            data_wdata = $urandom;
        end
        mem_addr_ok = 1'($urandom);
        mem_data_ok = ($urandom_range(0, 9) < 4);
        mem_rdata   = $urandom;
        #1;

        gnt = 0;
        if (held >= 0) begin
            exp_req = 1'b1;
            gnt     = held;
        end else begin
            exp_req = (owners.size() < OUTSTANDING) && (inst_req || data_req);
            if (inst_req && data_req) begin
`ifdef MEM_ARB_RR_EN
                gnt = (last_gnt == 1) ? 0 : 1;
`else
                gnt = 1;
`endif
            end else begin
                gnt = data_req ? 1 : 0;
            end
        end
        hs   = exp_req && mem_addr_ok;
        pop  = mem_data_ok && (owners.size() > 0);
        head = (owners.size() > 0) ? owners[0] : 0;

        check("outstanding_cnt", 64'(outstanding_cnt), 64'(owners.size()));
        check("mem_req", 64'(mem_req), 64'(exp_req));
        if (exp_req) begin
            check("mem_addr", 64'(mem_addr), 64'(gnt ? data_addr : inst_addr));
            check("mem_wdata", 64'(mem_wdata), 64'(gnt ? data_wdata : inst_wdata));
            check("mem_ctrl", 64'({mem_wr, mem_size, mem_wstrb}),
                  64'(gnt ? {data_wr, data_size, data_wstrb} : {inst_wr, inst_size, inst_wstrb}));
        end
        check("inst_addr_ok", 64'(inst_addr_ok), 64'(hs && gnt == 0));
        check("data_addr_ok", 64'(data_addr_ok), 64'(hs && gnt == 1));
        check("inst_data_ok", 64'(inst_data_ok), 64'(pop && head == 0));
        check("data_data_ok", 64'(data_data_ok), 64'(pop && head == 1));
        check("inst_rdata", 64'(inst_rdata), 64'(mem_rdata));
        check("data_rdata", 64'(data_rdata), 64'(mem_rdata));

        @(posedge clk);
        if (pop) void'(owners.pop_front());
        if (hs) begin
            owners.push_back(gnt);
            last_gnt = gnt;
            held     = -1;
        end else if (exp_req) begin
            held = gnt;
        end
        pend_i = inst_req && !(hs && gnt == 0);
        pend_d = data_req && !(hs && gnt == 1);
    endtask

    initial begin
        bit found;
        resetn      = 1'b0;
        inst_req    = 1'b0; inst_wr = 1'b0; inst_size = '0; inst_wstrb = '0;
        inst_addr   = '0;   inst_wdata = '0;
        data_req    = 1'b1; data_wr = 1'b0; data_size = '0; data_wstrb = '0;
        data_addr   = '0;   data_wdata = '0;
        mem_addr_ok = 1'b1;
        mem_data_ok = 1'b1;
        mem_rdata   = '0;
        model_reset();

        // Outputs held quiet during reset even with requests and handshakes present
        repeat (2) @(posedge clk);
        #1;
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_cnt", 64'(outstanding_cnt), 64'(0));
        check("rst_data_addr_ok", 64'(data_addr_ok), 64'(0));
        check("rst_data_ok", 64'({inst_data_ok, data_data_ok}), 64'(0));
        @(negedge clk);
        data_req = 1'b0;
        resetn   = 1'b1;

        repeat (1500) run_cycle();

        // Run on until the data requester holds the port, then reset mid-hold
        found = 0;
        for (int i = 0; i < 1000 && !found; i++) begin
            run_cycle();
            if (held == 1) found = 1;
        end
        check("reach_hold_d", 64'(found), 64'(1));
        @(negedge clk);
        cyc++;
        mem_addr_ok = 1'b1;
        resetn      = 1'b0;
        #1;
        check("midrst_mem_req", 64'(mem_req), 64'(0));
        check("midrst_cnt", 64'(outstanding_cnt), 64'(0));
        check("midrst_addr_ok", 64'({inst_addr_ok, data_addr_ok}), 64'(0));
        model_reset();
        @(negedge clk);
        inst_req = 1'b0;
        data_req = 1'b0;
        resetn   = 1'b1;

        repeat (1000) run_cycle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
